// File: rtl/rtype_seq_ctrl_pkg.sv
// Shared definitions for the R-format sequencer: state encoding, opcode and
// sentinel constants, instruction field positions and small helpers.
package rtype_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  localparam logic [5:0]  OPC_RTYPE = 6'd0;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  function automatic logic [31:0] pc_add4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // The sentinel carries opcode 6'h3F, so it never decodes as R-type.
  function automatic logic is_rtype(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_RTYPE;
  endfunction

endpackage

// File: rtl/rtype_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer owning PC, IR and the retired
// counter; every output is a register updated on the rising clock edge.
module rtype_seq_ctrl
  import rtype_pkg::*;
#(
  parameter logic [31:0] PC_LIMIT = 32'h0000_0100,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      start_pc,
  input  logic             imem_valid,
  input  logic [31:0]      imem_data,
  output logic [31:0]      pc,
  output logic [31:0]      ir,
  output logic             opnd_en,
  output logic             alu_en,
  output logic             reg_write,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e             state_q;
  logic [31:0]        pc_q;
  logic [31:0]        ir_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               opnd_en_q;
  logic               alu_en_q;
  logic               reg_write_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [31:0]        pc_plus4;

  assign pc_plus4 = pc_add4(pc_q);

  // Strobes are registered one state early so they are high exactly during
  // the state that owns them. The limit test uses >= so a start_pc at or
  // past PC_LIMIT still retires one instruction and then halts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= 32'd0;
      ir_q        <= 32'd0;
      cnt_q       <= '0;
      opnd_en_q   <= 1'b0;
      alu_en_q    <= 1'b0;
      reg_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      opnd_en_q   <= 1'b0;
      alu_en_q    <= 1'b0;
      reg_write_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pc_q    <= start_pc;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (imem_valid) begin
            ir_q      <= imem_data;
            opnd_en_q <= is_rtype(imem_data);
            state_q   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (ir_q == HALT_WORD) begin
            done_q  <= 1'b1;
            state_q <= ST_HALT;
          end else if (!is_rtype(ir_q)) begin
            err_q   <= 1'b1;
            state_q <= ST_ERR;
          end else begin
            alu_en_q <= 1'b1;
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          reg_write_q <= (ir_q[RD_MSB:RD_LSB] != 5'd0);
          state_q     <= ST_WB;
        end
        ST_WB: begin
          pc_q <= pc_plus4;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (pc_plus4 >= PC_LIMIT) begin
            done_q  <= 1'b1;
            state_q <= ST_HALT;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_HALT: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        ST_ERR: begin
          state_q <= ST_ERR;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pc        = pc_q;
  assign ir        = ir_q;
  assign opnd_en   = opnd_en_q;
  assign alu_en    = alu_en_q;
  assign reg_write = reg_write_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_rtype_seq_ctrl.sv
// Bench for rtype_seq_ctrl: directed vector table, hand-written corner
// sequences, and random programs checked cycle by cycle against a schedule.
module tb_rtype_seq_ctrl;

  localparam logic [31:0] LIMIT = 32'h0000_0100;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset, start, imem_valid;
  logic [31:0] start_pc, imem_data, pc, ir;
  logic        opnd_en, alu_en, reg_write, busy, done, err;
  logic [15:0] instr_cnt;

  logic [31:0] mem [0:127];
  assign imem_data = mem[pc[8:2]];

  always #5 clk = ~clk;

  rtype_seq_ctrl #(.PC_LIMIT(LIMIT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .imem_valid(imem_valid), .imem_data(imem_data), .pc(pc), .ir(ir),
    .opnd_en(opnd_en), .alu_en(alu_en), .reg_write(reg_write),
    .busy(busy), .done(done), .err(err), .instr_cnt(instr_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; imem_valid = 1'b0; start_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 128; i++) mem[i] = HALTW;
  endtask

  task automatic kick(input logic [31:0] spc);
    start_pc = spc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Directed table: summary counts and the cycle (1 = first FETCH) on which
  // done or err is first seen.
  typedef struct {
    logic [31:0] spc, w0, w1;
    int          stall, opnd, rw, cnt, endc;
    logic        err;
    logic [31:0] fpc;
  } vec_t;
  vec_t tab [0:7];

  task automatic run_entry(input vec_t v, output int opc, output int rwc, output int endc);
    int k;
    fill_halt();
    mem[v.spc[8:2]]        = v.w0;
    mem[v.spc[8:2] + 7'd1] = v.w1;
    do_reset();
    kick(v.spc);
    opc = 0; rwc = 0; endc = -1; k = 1;
    while (k <= 40 && endc < 0) begin
      if (opnd_en) opc++;
      if (reg_write) rwc++;
      if (done || err) endc = k;
      else begin
        imem_valid = (k > v.stall);
        @(posedge clk);
        #1 k++;
      end
    end
  endtask

  // Random-program reference: expected outputs per cycle, derived from the
  // instruction timing rules (fetch + stalls, decode, exec, wb, halt).
  typedef struct {
    logic        busy, done, err, opnd, alu, rw, infetch, vld;
    logic [31:0] pc, ir;
    logic [15:0] cnt;
  } cyc_t;
  cyc_t exp_q [0:511];
  int   stall_tab [0:63];

  function automatic void set_cyc(int k, logic b, logic d, logic e, logic o, logic a,
                                  logic r, logic f, logic v, logic [31:0] p,
                                  logic [31:0] i, logic [15:0] n);
    exp_q[k] = '{busy:b, done:d, err:e, opnd:o, alu:a, rw:r, infetch:f, vld:v,
                 pc:p, ir:i, cnt:n};
  endfunction

  task automatic build_model(input logic [31:0] spc, output int ncyc);
    logic [31:0] p, w, np, cir;
    logic [15:0] cnt;
    int c, s, fi;
    p = spc; c = 1; cnt = 0; fi = 0; cir = 32'd0; ncyc = 0;
    while (ncyc == 0 && fi < 64) begin
      s = stall_tab[fi]; fi++;
      w = mem[p[8:2]];
      for (int j = 0; j <= s; j++)
        set_cyc(c + j, 1, 0, 0, 0, 0, 0, 1, (j == s), p, cir, cnt);
      cir = w; c = c + s + 1;
      if (w == HALTW) begin
        set_cyc(c,     1, 0, 0, 0, 0, 0, 0, 0, p, cir, cnt);
        set_cyc(c + 1, 1, 1, 0, 0, 0, 0, 0, 0, p, cir, cnt);
        set_cyc(c + 2, 0, 0, 0, 0, 0, 0, 0, 0, p, cir, cnt);
        ncyc = c + 2;
      end else if (w[31:26] != 6'd0) begin
        set_cyc(c, 1, 0, 0, 0, 0, 0, 0, 0, p, cir, cnt);
        for (int j = 1; j <= 4; j++)
          set_cyc(c + j, 1, 0, 1, 0, 0, 0, 0, 0, p, cir, cnt);
        ncyc = c + 4;
      end else begin
        set_cyc(c,     1, 0, 0, 1, 0, 0, 0, 0, p, cir, cnt);
        set_cyc(c + 1, 1, 0, 0, 0, 1, 0, 0, 0, p, cir, cnt);
        set_cyc(c + 2, 1, 0, 0, 0, 0, (w[15:11] != 5'd0), 0, 0, p, cir, cnt);
        cnt = cnt + 16'd1; np = p + 32'd4; c = c + 3;
        if (np >= LIMIT) begin
          set_cyc(c,     1, 1, 0, 0, 0, 0, 0, 0, np, cir, cnt);
          set_cyc(c + 1, 0, 0, 0, 0, 0, 0, 0, 0, np, cir, cnt);
          ncyc = c + 1;
        end
        p = np;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int opc, rwc, endc, ncyc, w, len;
    logic [31:0] word;

    tab[0] = '{32'h00, 32'h0022_1820, HALTW,        0, 1, 1, 1,  7, 1'b0, 32'h004};
    tab[1] = '{32'h00, 32'h0022_1820, HALTW,        3, 1, 1, 1, 10, 1'b0, 32'h004};
    tab[2] = '{32'h00, 32'h0022_0020, HALTW,        0, 1, 0, 1,  7, 1'b0, 32'h004};
    tab[3] = '{32'h00, 32'h8C22_0000, HALTW,        0, 0, 0, 0,  3, 1'b1, 32'h000};
    tab[4] = '{32'hFC, 32'h0022_1820, HALTW,        0, 1, 1, 1,  5, 1'b0, 32'h100};
    tab[5] = '{32'h100,32'h0022_1820, HALTW,        0, 1, 1, 1,  5, 1'b0, 32'h104};
    tab[6] = '{32'h40, HALTW,         32'h0022_1820,0, 0, 0, 0,  3, 1'b0, 32'h040};
    tab[7] = '{32'h08, 32'h0022_1820, 32'h0109_5020,0, 2, 2, 2, 11, 1'b0, 32'h010};

    // Reset and idle
    fill_halt();
    do_reset();
    chk("reset_state", {busy, done, err, opnd_en, alu_en, reg_write, instr_cnt, pc, ir}, '0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk($sformatf("idle%0d", i), {busy, done, err, opnd_en, alu_en, reg_write, pc}, '0);
    end

    for (int t = 0; t < 8; t++) begin
      run_entry(tab[t], opc, rwc, endc);
      chk($sformatf("vec%0d end_cycle", t), endc, tab[t].endc);
      chk($sformatf("vec%0d opnd_cnt", t), opc, tab[t].opnd);
      chk($sformatf("vec%0d wr_cnt", t), rwc, tab[t].rw);
      chk($sformatf("vec%0d instr_cnt", t), instr_cnt, tab[t].cnt);
      chk($sformatf("vec%0d err", t), err, tab[t].err);
      chk($sformatf("vec%0d pc", t), pc, tab[t].fpc);
    end

    // ERR is sticky, ignores start, and only reset clears it
    run_entry(tab[3], opc, rwc, endc);
    start_pc = 32'h80; start = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("err_ignores_start", {err, busy, pc}, {1'b1, 1'b1, 32'h0});
    do_reset();
    chk("err_cleared", {err, busy}, 2'b00);

    // Reset while in EXEC suppresses the write
    fill_halt();
    mem[0] = 32'h0022_1820;
    do_reset();
    kick(32'h0);
    imem_valid = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 chk("exec_reached", alu_en, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_in_exec", {reg_write, busy, instr_cnt, pc}, '0);
    @(posedge clk);
    #1 chk("reset_in_exec_after", {reg_write, busy}, 2'b00);

    // Random programs
    for (int it = 0; it < 30; it++) begin
      fill_halt();
      w   = $urandom_range(0, 63);
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        word = {6'd0, 26'($urandom)};
        if ($urandom_range(0, 3) == 0) word[15:11] = 5'd0;
        mem[(w + j) % 128] = word;
      end
      if ($urandom_range(0, 4) == 0) mem[(w + len) % 128] = {6'h23, 26'($urandom)};
      for (int j = 0; j < 64; j++) stall_tab[j] = $urandom_range(0, 3);
      do_reset();
      build_model(32'(w * 4), ncyc);
      kick(32'(w * 4));
      for (int k = 1; k <= ncyc; k++) begin
        chk($sformatf("rand%0d cyc%0d ctl", it, k),
            {busy, done, err, opnd_en, alu_en, reg_write, instr_cnt},
            {exp_q[k].busy, exp_q[k].done, exp_q[k].err, exp_q[k].opnd,
             exp_q[k].alu, exp_q[k].rw, exp_q[k].cnt});
        chk($sformatf("rand%0d cyc%0d pc_ir", it, k), {pc, ir}, {exp_q[k].pc, exp_q[k].ir});
        imem_valid = exp_q[k].infetch ? exp_q[k].vld : 1'($urandom);
        @(posedge clk);
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
